// File: rtl/quad_scan_ctrl.sv
// quad_scan_ctrl: time-multiplexed quadrature decoder for N_ENC encoders with a single-cycle read port.
// Define QUAD_ERR_EN to add per-encoder sticky illegal-transition flags returned on rd_err.
module quad_scan_ctrl #(
    parameter int N_ENC = 4,
    parameter int CNT_W = 16,
    parameter int DIV   = 50,
    localparam int SEL_W = (N_ENC > 1) ? $clog2(N_ENC) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_ENC-1:0] quadA,
    input  logic [N_ENC-1:0] quadB,
    input  logic             clr,
    input  logic             rd_req,
    input  logic [SEL_W-1:0] rd_sel,
    output logic             rd_ack,
    output logic [CNT_W-1:0] rd_count,
    output logic             rd_err
);
    localparam int PRE_W = $clog2(DIV);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t           r_state, w_state_nxt;
    logic [SEL_W-1:0] r_idx, w_idx_nxt;
    logic [PRE_W-1:0] r_pre;
    logic [N_ENC-1:0] r_a1, r_a2, r_b1, r_b2;
    logic [1:0]       r_prev [N_ENC];
    logic [CNT_W-1:0] r_cnt [N_ENC];
    logic             r_prime;
    logic             w_tick, w_last, w_step, w_inc, w_dec, w_ill, w_rd_ok, w_err_rd;
    logic [3:0]       w_code;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a1 <= '0;
            r_a2 <= '0;
            r_b1 <= '0;
            r_b2 <= '0;
        end else begin
            r_a1 <= quadA;
            r_a2 <= r_a1;
            r_b1 <= quadB;
            r_b2 <= r_b1;
        end
    end
    assign w_tick  = r_pre == PRE_W'(DIV - 1);
    assign w_code  = {r_prev[r_idx], r_a2[r_idx], r_b2[r_idx]};
    assign w_inc   = w_code inside {4'b0010, 4'b0100, 4'b1011, 4'b1101};
    assign w_dec   = w_code inside {4'b0001, 4'b0111, 4'b1000, 4'b1110};
    assign w_ill   = w_code inside {4'b0011, 4'b0110, 4'b1001, 4'b1100};
    assign w_step  = (r_state == SCAN) && !r_prime;
    assign w_rd_ok = {1'b0, rd_sel} < (SEL_W + 1)'(N_ENC);
    always_comb begin
        w_last      = r_idx == SEL_W'(N_ENC - 1);
        w_state_nxt = (r_state == IDLE) ? (w_tick ? SCAN : IDLE) : (w_last ? IDLE : SCAN);
        w_idx_nxt   = (r_state == SCAN && !w_last) ? r_idx + 1'b1 : '0;
    end
    // The priming scan only loads prev, so stale history never produces a count after reset/clr.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_pre   <= '0;
            r_prime <= 1'b1;
            for (int k = 0; k < N_ENC; k++) r_cnt[k] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_pre   <= w_tick ? '0 : r_pre + 1'b1;
            if (r_state == SCAN) begin
                r_prev[r_idx] <= {r_a2[r_idx], r_b2[r_idx]};
                if (w_last) r_prime <= 1'b0;
                if (w_step && (w_inc || w_dec))
                    r_cnt[r_idx] <= w_inc ? r_cnt[r_idx] + 1'b1 : r_cnt[r_idx] - 1'b1;
            end
        end
    end
`ifdef QUAD_ERR_EN
    logic [N_ENC-1:0] r_err;
    // A set from the scan takes priority over a read-clear on the same encoder.
    always_ff @(posedge clk) begin
        if (reset || clr) r_err <= '0;
        else
            for (int k = 0; k < N_ENC; k++)
                if (w_step && w_ill && r_idx == SEL_W'(k)) r_err[k] <= 1'b1;
                else if (rd_req && rd_sel == SEL_W'(k)) r_err[k] <= 1'b0;
    end
    assign w_err_rd = w_rd_ok && r_err[rd_sel];
`else
    assign w_err_rd = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ack   <= 1'b0;
            rd_count <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_ack <= rd_req;
            if (rd_req) begin
                rd_count <= w_rd_ok ? r_cnt[rd_sel] : '0;
                rd_err   <= w_err_rd;
            end
        end
    end
endmodule

// File: tb/tb_quad_scan_ctrl.sv
// tb_quad_scan_ctrl: directed and randomized checks of quad_scan_ctrl against a phase-difference model.
module tb_quad_scan_ctrl;
    localparam int N_ENC = 5;
    localparam int CNT_W = 16;
    localparam int DIV   = 12;
    localparam int SEL_W = 3;
    localparam int HOLD  = 2 * DIV;
`ifdef QUAD_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    logic             clk = 1'b0, reset = 1'b1, clr = 1'b0, rd_req = 1'b0;
    logic [N_ENC-1:0] quadA = '0, quadB = '0;
    logic [SEL_W-1:0] rd_sel = '0;
    logic             rd_ack, rd_err;
    logic [CNT_W-1:0] rd_count;
    int               checks = 0, failures = 0;
    logic [1:0]       m_ab [N_ENC];
    logic [CNT_W-1:0] m_cnt [N_ENC];
    logic             m_err [N_ENC];
    bit               m_prime;
    int               tb_pre = 0;
    int               ph_tab [4] = '{0, 3, 1, 2};
    quad_scan_ctrl #(.N_ENC(N_ENC), .CNT_W(CNT_W), .DIV(DIV)) dut (
        .clk(clk), .reset(reset), .quadA(quadA), .quadB(quadB), .clr(clr),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack), .rd_count(rd_count), .rd_err(rd_err)
    );
    always #5 clk = ~clk;
    always @(posedge clk) tb_pre <= (reset || clr || tb_pre == DIV - 1) ? 0 : tb_pre + 1;
    // Position is the gray-code phase; a quarter-turn forward is +1, backward -1, half-turn is illegal.
    task automatic set_enc(input int k, input logic [1:0] ab);
        int d;
        d = (ph_tab[ab] - ph_tab[m_ab[k]] + 4) % 4;
        if (!m_prime) begin
            if (d == 1) m_cnt[k] = m_cnt[k] + 1'b1;
            if (d == 3) m_cnt[k] = m_cnt[k] - 1'b1;
            if (d == 2 && ERR_EN) m_err[k] = 1'b1;
        end
        m_ab[k] = ab;
        quadA[k] = ab[1];
        quadB[k] = ab[0];
    endtask
    task automatic hold();
        repeat (HOLD) @(posedge clk);
        m_prime = 1'b0;
    endtask
    task automatic model_clear();
        for (int k = 0; k < N_ENC; k++) begin
            m_cnt[k] = '0;
            m_err[k] = 1'b0;
        end
        m_prime = 1'b1;
    endtask
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask
    task automatic do_read(input int sel, output logic pre, output logic ack,
                           output logic [CNT_W-1:0] cnt, output logic err);
        @(negedge clk);
        pre = rd_ack;
        rd_req = 1'b1;
        rd_sel = SEL_W'(sel);
        @(negedge clk);
        rd_req = 1'b0;
        ack = rd_ack;
        cnt = rd_count;
        err = rd_err;
        if (sel < N_ENC) m_err[sel] = 1'b0;
    endtask
    task automatic test_reset();
        logic pre, ack, err;
        logic [CNT_W-1:0] cnt;
        do_reset();
        checks++; if (rd_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got %b expected 0", rd_ack); end
        checks++; if (rd_count !== '0) begin failures++; $display("FAIL reset_count got %h expected 0000", rd_count); end
        checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL reset_err got %b expected 0", rd_err); end
        hold();
        for (int s = 0; s < N_ENC; s++) begin
            do_read(s, pre, ack, cnt, err);
            checks++; if (pre !== 1'b0 || ack !== 1'b1) begin failures++; $display("FAIL reset_read_ack sel %0d got pre=%b ack=%b expected pre=0 ack=1", s, pre, ack); end
            checks++; if (cnt !== '0) begin failures++; $display("FAIL reset_read_count sel %0d got %h expected 0000", s, cnt); end
        end
    endtask
    task automatic test_forward();
        logic pre, ack, err;
        logic [CNT_W-1:0] cnt;
        logic [1:0] seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        do_reset();
        hold();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_enc(0, seq[i]);
            hold();
        end
        do_read(0, pre, ack, cnt, err);
        checks++; if (pre !== 1'b0 || ack !== 1'b1) begin failures++; $display("FAIL fwd_ack got pre=%b ack=%b expected pre=0 ack=1", pre, ack); end
        checks++; if (cnt !== 16'h0004) begin failures++; $display("FAIL fwd_count got %h expected 0004", cnt); end
    endtask
    task automatic test_reverse();
        logic pre, ack, err;
        logic [CNT_W-1:0] cnt;
        logic [1:0] seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        do_reset();
        hold();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_enc(2, seq[i]);
            hold();
        end
        do_read(2, pre, ack, cnt, err);
        checks++; if (cnt !== 16'hFFFC) begin failures++; $display("FAIL rev_count got %h expected fffc", cnt); end
        for (int s = 0; s < N_ENC; s++) begin
            if (s == 2) continue;
            do_read(s, pre, ack, cnt, err);
            checks++; if (cnt !== '0) begin failures++; $display("FAIL rev_other sel %0d got %h expected 0000", s, cnt); end
        end
    endtask
    task automatic test_wrap();
        logic pre, ack, err;
        logic [CNT_W-1:0] cnt;
        do_reset();
        hold();
        @(negedge clk);
        set_enc(0, 2'b01);
        hold();
        do_read(0, pre, ack, cnt, err);
        checks++; if (cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_down got %h expected ffff", cnt); end
        @(negedge clk);
        set_enc(0, 2'b00);
        hold();
        do_read(0, pre, ack, cnt, err);
        checks++; if (cnt !== 16'h0000) begin failures++; $display("FAIL wrap_up got %h expected 0000", cnt); end
    endtask
    task automatic test_illegal();
        logic pre, ack, err;
        logic [CNT_W-1:0] cnt;
        do_reset();
        hold();
        @(negedge clk);
        set_enc(1, 2'b11);
        hold();
        do_read(1, pre, ack, cnt, err);
        checks++; if (cnt !== '0) begin failures++; $display("FAIL illegal_count got %h expected 0000", cnt); end
        checks++; if (err !== ERR_EN) begin failures++; $display("FAIL illegal_err1 got %b expected %b", err, ERR_EN); end
        do_read(1, pre, ack, cnt, err);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL illegal_err2 got %b expected 0", err); end
    endtask
    task automatic test_clr();
        logic pre, ack, err;
        logic [CNT_W-1:0] cnt;
        do_reset();
        hold();
        @(negedge clk);
        for (int k = 0; k < N_ENC; k++) set_enc(k, 2'b10);
        hold();
        @(negedge clk);
        for (int k = 0; k < N_ENC; k++) set_enc(k, 2'b11);
        hold();
        for (int i = 0; i < DIV + 1 && tb_pre != 2; i++) @(negedge clk);
        if (tb_pre != 2) @(negedge clk);
        clr = 1'b1;
        rd_req = 1'b1;
        rd_sel = '0;
        @(negedge clk);
        clr = 1'b0;
        rd_req = 1'b0;
        checks++; if (rd_ack !== 1'b1 || rd_count !== 16'h0002) begin failures++; $display("FAIL clr_same_edge_read got ack=%b count=%h expected ack=1 count=0002", rd_ack, rd_count); end
        model_clear();
        set_enc(0, 2'b01);
        set_enc(1, 2'b00);
        hold();
        for (int s = 0; s < N_ENC; s++) begin
            do_read(s, pre, ack, cnt, err);
            checks++; if (cnt !== '0 || err !== 1'b0) begin failures++; $display("FAIL clr_read sel %0d got count=%h err=%b expected count=0000 err=0", s, cnt, err); end
        end
        @(negedge clk);
        set_enc(0, 2'b00);
        hold();
        do_read(0, pre, ack, cnt, err);
        checks++; if (cnt !== 16'h0001) begin failures++; $display("FAIL clr_after_prime got %h expected 0001", cnt); end
    endtask
    task automatic test_random();
        logic pre, ack, err, ex_err;
        logic [CNT_W-1:0] cnt, ex_cnt;
        int s;
        do_reset();
        hold();
        for (int it = 0; it < 25; it++) begin
            @(negedge clk);
            for (int k = 0; k < N_ENC; k++) set_enc(k, 2'($urandom_range(0, 3)));
            hold();
            s = (it < 20) ? $urandom_range(0, 7) : it - 20;
            ex_cnt = (s < N_ENC) ? m_cnt[s] : '0;
            ex_err = (s < N_ENC) ? m_err[s] : 1'b0;
            do_read(s, pre, ack, cnt, err);
            checks++; if (ack !== 1'b1 || cnt !== ex_cnt || err !== ex_err) begin failures++; $display("FAIL random_read it %0d sel %0d got ack=%b count=%h err=%b expected ack=1 count=%h err=%b", it, s, ack, cnt, err, ex_cnt, ex_err); end
        end
    endtask
    task automatic test_back_to_back();
        int ps, s;
        logic [CNT_W-1:0] ex_cnt;
        logic ex_err;
        ps = 0;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            if (i > 0) begin
                ex_cnt = (ps < N_ENC) ? m_cnt[ps] : '0;
                ex_err = (ps < N_ENC) ? m_err[ps] : 1'b0;
                if (ps < N_ENC) m_err[ps] = 1'b0;
                checks++; if (rd_ack !== 1'b1 || rd_count !== ex_cnt || rd_err !== ex_err) begin failures++; $display("FAIL b2b cycle %0d sel %0d got ack=%b count=%h err=%b expected ack=1 count=%h err=%b", i, ps, rd_ack, rd_count, rd_err, ex_cnt, ex_err); end
            end
            if (i < 20) begin
                s = (i == 13) ? 7 : i % (N_ENC + 1);
                rd_req = 1'b1;
                rd_sel = SEL_W'(s);
                ps = s;
            end else rd_req = 1'b0;
        end
        @(negedge clk);
        checks++; if (rd_ack !== 1'b0) begin failures++; $display("FAIL b2b_end_ack got %b expected 0", rd_ack); end
    endtask
    initial begin
        for (int k = 0; k < N_ENC; k++) m_ab[k] = 2'b00;
        model_clear();
        test_reset();
        test_forward();
        test_reverse();
        test_wrap();
        test_illegal();
        test_clr();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/quad_scan_ctrl.md
# quad_scan_ctrl

Clocked scan controller that shares one quadrature-decode step among several rotary encoders. It synchronizes all A/B inputs, time-multiplexes a single decode step across the encoders on a fixed sample tick, and maintains one signed position counter per encoder. A single-cycle read port lets the host fetch any counter. It sits between the board-level encoder pins and the host register interface.

## Interface
- `N_ENC`, 4: number of encoders, 1..16
- `CNT_W`, 16: counter width, bits
- `DIV`, 50: clocks per sample tick; must satisfy DIV > N_ENC
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high reset
- `quadA` in N_ENC: channel A per encoder, asynchronous
- `quadB` in N_ENC: channel B per encoder, asynchronous
- `clr` in 1: synchronous clear of all counters and flags
- `rd_req` in 1: read request, sampled each clock
- `rd_sel` in max(1,$clog2(N_ENC)): encoder index to read
- `rd_ack` out 1: one-cycle read-valid pulse
- `rd_count` out CNT_W: counter value returned by the read
- `rd_err` out 1: illegal-transition flag for the selected encoder (see Configuration)

## Operation
- Synchronizer: two flops per `quadA`/`quadB` bit, reset to 0. Decode uses only second-stage values `sA`/`sB`.
- Prescaler counts 0..DIV-1 and wraps. `tick` is asserted in the cycle it holds DIV-1.
- FSM states:
  - IDLE: on `tick`, go to SCAN with idx=0.
  - SCAN: process encoder idx each cycle. After idx=N_ENC-1, return to IDLE.
- Decode step for idx: code = {prevA, prevB, sA[idx], sB[idx]}.
  - +1 for codes 0010, 0100, 1011, 1101.
  - -1 for codes 0001, 0111, 1000, 1110.
  - 0 for codes 0000, 0101, 1010, 1111.
  - Illegal (0 change) for codes 0011, 0110, 1001, 1100.
  - After the step, prev[idx] is set to {sA[idx], sB[idx]}.
- Counter arithmetic: two's complement, modulo 2^CNT_W. 0x7FFF+1 = 0x8000 and 0x0000-1 = 0xFFFF, with no saturation.
- Priming: the first scan after `reset` or `clr` only loads `prev`. Counters stay unchanged and no error flag is set. A `priming` flag clears when that scan completes.
- `clr`, in any state:
  - counters, flags and prescaler go to 0
  - FSM goes to IDLE
  - priming is set
  - a scan in progress is aborted
- `reset` has the same effect as `clr`, and also clears the synchronizers, `rd_ack`, `rd_count` and `rd_err`.

## Timing
- Reset values: `rd_ack`=0, `rd_count`=0, `rd_err`=0. All counters are 0, FSM is IDLE, prescaler is 0.
- First tick comes DIV clocks after `reset` deasserts. Encoder i is processed i+1 cycles after the tick cycle.
- Input-to-count latency: 2 synchronizer clocks, plus wait for the next tick, plus i+1 cycles.
- Read handshake:
  - `rd_req` is sampled at edge T. `rd_ack`=1 during cycle T+1, together with `rd_count` and `rd_err`.
  - Returned values are the state before any update at edge T (a same-edge scan update is not visible).
  - `rd_ack` stays high on back-to-back requests, one response per cycle. No stall, no ready signal.
  - If `rd_sel` ≥ N_ENC, `rd_count`=0 and `rd_err`=0, and `rd_ack` still pulses.
- `clr` and `rd_req` at the same edge: the read returns the pre-clear values.
- Outputs hold their last value while `rd_ack`=0.

## Configuration
- `QUAD_ERR_EN` defined:
  - per-encoder sticky error flag, set by an illegal code during a non-priming scan
  - `rd_err` returns the flag, and the read clears it
  - if a set and a read-clear hit the same index at the same edge, the set wins
- `QUAD_ERR_EN` undefined:
  - no flag storage; illegal codes are treated as 0 change
  - `rd_err` is tied to 0

## Test plan
- Reset, then encoder 0 steps AB 00→10→11→01→00, each step held ≥2·DIV clocks. Read sel 0 → `rd_count`=0x0004, one cycle after `rd_req`.
- Same sequence in reverse on encoder 2, other encoders static. Read sel 2 → 0xFFFC; read sel 0/1/3 → 0x0000.
- Preload counter 0 to 0xFFFF with -1 steps from 0, then one +1 step. Read → 0x0000 (wrap).
- Encoder 1 jumps 00→11 within one tick period:
  - with `QUAD_ERR_EN`: count unchanged, first read `rd_err`=1, second read `rd_err`=0
  - without `QUAD_ERR_EN`: `rd_err`=0
- Assert `clr` mid-SCAN, with A/B at 11 on all encoders before the clear. All reads → 0. First scan after the clear makes no count or error change; the next +1 step counts normally.
- `rd_req` every cycle for 20 cycles with `rd_sel` cycling 0..N_ENC and one out-of-range index. `rd_ack` is high for 20 consecutive cycles; the out-of-range read returns 0.
